iq_tx_interleaver: RTL and testbench

- Downstream stage of top_tx. Consumes the parallel signed 16-bit I/Q sample pairs that top_tx produces.
- Buffers the pairs in a small FIFO and emits them on a single 16-bit DAC-facing bus, interleaved I then Q, under a valid/ready handshake.
- Absorbs rate mismatch between the transmit chain and the DAC interface, and counts dropped and underrun events for debug.

---
 rtl/iq_tx_interleaver.sv | 169 ++++++++++++++++
 tb/tb_iq_tx_interleaver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_tx_interleaver.sv
// iq_tx_interleaver
// Buffers parallel signed 16-bit I/Q pairs from top_tx in a small FIFO and
// serialises them onto one 16-bit DAC-facing bus, I word first then Q word,
// under a valid/ready handshake. Counts dropped pairs and stream underruns.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-high; clears all state
//   in_valid     - din_i/din_q hold a valid pair
//   in_ready     - FIFO can accept a pair (fill < DEPTH)
//   din_i, din_q - signed I and Q samples
//   out_valid    - dout holds a valid word
//   out_ready    - downstream accepts dout this cycle
//   dout         - interleaved sample word
//   dout_sel     - 0 = dout is I, 1 = dout is Q
//   fill         - FIFO occupancy in pairs
//   drop_cnt     - pairs offered while full (saturating)
//   underrun_cnt - stream breaks after a Q word (saturating)
//
// Optional feature macro: IQ_TX_OFFSET_BINARY_EN
//   When defined, the MSB of every output word is inverted, converting
//   two's complement samples to offset binary for unsigned DACs.
module iq_tx_interleaver #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              din_i,
    input  logic [15:0]              din_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              dout,
    output logic                     dout_sel,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND_I, SEND_Q} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   head;
    logic [15:0]   pair_i;
    logic [15:0]   pair_q;
    logic          push;
    logic          pop;
    logic          drop;
    logic          underrun;
    logic          have_data;

    function automatic logic [15:0] to_dac(input logic [15:0] s);
`ifdef IQ_TX_OFFSET_BINARY_EN
        return {~s[15], s[14:0]};
`else
        return s;
`endif
    endfunction

    // in_ready comes straight from registered fill, so a pop at full only
    // frees space for the following cycle.
    assign in_ready  = (fill < FULL);
    assign have_data = (fill != '0);
    assign push      = in_valid && in_ready;
    assign drop      = in_valid && !in_ready;
    assign head      = mem[rd_ptr];

    // The FIFO head is consumed only when the pair register loads: from IDLE,
    // or at the end of a Q transfer when more data is waiting.
    assign pop      = have_data && ((state == IDLE) || (state == SEND_Q && out_ready));
    assign underrun = (state == SEND_Q) && out_ready && !have_data;

    // Storage array carries no reset; stale entries are unreachable once
    // the pointers and fill are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {din_i, din_q};
        end
    end

    // Pointers, occupancy and the saturating debug counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            drop_cnt     <= '0;
            underrun_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (underrun && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

    // Output FSM. Leaving IDLE, the pair is loaded first and the I word is
    // presented one cycle later (SEND_I with out_valid still low). On a
    // back-to-back Q->I transition the next I word is driven directly from
    // the FIFO head so there is no bubble on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            dout      <= '0;
            dout_sel  <= 1'b0;
            pair_i    <= '0;
            pair_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (have_data) begin
                        pair_i <= head[31:16];
                        pair_q <= head[15:0];
                        state  <= SEND_I;
                    end
                end
                SEND_I: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        dout      <= to_dac(pair_i);
                        dout_sel  <= 1'b0;
                    end else if (out_ready) begin
                        dout     <= to_dac(pair_q);
                        dout_sel <= 1'b1;
                        state    <= SEND_Q;
                    end
                end
                SEND_Q: begin
                    if (out_ready) begin
                        if (have_data) begin
                            pair_i   <= head[31:16];
                            pair_q   <= head[15:0];
                            dout     <= to_dac(head[31:16]);
                            dout_sel <= 1'b0;
                            state    <= SEND_I;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_tx_interleaver.sv
// tb_iq_tx_interleaver
// Directed testbench for iq_tx_interleaver. A DEPTH=16 instance covers the
// data path, latency, full/drop behaviour, pointer wrap and async reset; a
// second CNT_W=4, DEPTH=4 instance covers drop counter saturation.
// Build with +define+IQ_TX_OFFSET_BINARY_EN to exercise offset-binary output.
module tb_iq_tx_interleaver;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din_i;
    logic [15:0] din_q;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        dout_sel;
    logic [4:0]  fill;
    logic [15:0] drop_cnt;
    logic [15:0] underrun_cnt;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_dout;
    logic        s_dout_sel;
    logic [2:0]  s_fill;
    logic [3:0]  s_drop_cnt;
    logic [3:0]  s_underrun_cnt;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [16:0] exp_q [$];

`ifdef IQ_TX_OFFSET_BINARY_EN
    localparam logic [15:0] EXP5_I = 16'h0000;
    localparam logic [15:0] EXP5_Q = 16'h8000;
`else
    localparam logic [15:0] EXP5_I = 16'h8000;
    localparam logic [15:0] EXP5_Q = 16'h0000;
`endif

    iq_tx_interleaver #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_i(din_i), .din_q(din_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .dout_sel(dout_sel), .fill(fill),
        .drop_cnt(drop_cnt), .underrun_cnt(underrun_cnt)
    );

    iq_tx_interleaver #(.DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din_i(16'h1234), .din_q(16'h5678),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .dout(s_dout), .dout_sel(s_dout_sel), .fill(s_fill),
        .drop_cnt(s_drop_cnt), .underrun_cnt(s_underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dac(input logic [15:0] s);
`ifdef IQ_TX_OFFSET_BINARY_EN
        return s ^ 16'h8000;
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] i,
                                 input logic [15:0] q, input logic rdy);
        in_valid  = v;
        din_i     = i;
        din_q     = q;
        out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, expv);
    endtask

    initial begin
        int pushed;
        int cyc;
        logic sent;
        logic [15:0] ni;
        logic [15:0] nq;

        reset = 1'b1;
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_dout_sel", dout_sel, 0);
        checkOutput("rst_fill", fill, 0);
        checkOutput("rst_drop", drop_cnt, 0);
        checkOutput("rst_underrun", underrun_cnt, 0);

        // Two pairs, out_ready high: latency and interleave order
        applyStimulus(1'b1, 16'h0001, 16'hFFFF, 1'b1);
        tick();
        checkOutput("t1_valid_t1", out_valid, 0);
        applyStimulus(1'b1, 16'h7FFF, 16'h8000, 1'b1);
        tick();
        checkOutput("t1_valid_t2", out_valid, 0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        checkOutput("t1_valid_w0", out_valid, 1);
        checkOutput("t1_word0", {dout_sel, dout}, {1'b0, dac(16'h0001)});
        tick();
        checkOutput("t1_word1", {out_valid, dout_sel, dout}, {2'b11, dac(16'hFFFF)});
        tick();
        checkOutput("t1_word2", {out_valid, dout_sel, dout}, {2'b10, dac(16'h7FFF)});
        tick();
        checkOutput("t1_word3", {out_valid, dout_sel, dout}, {2'b11, dac(16'h8000)});
        tick();
        checkOutput("t1_idle_valid", out_valid, 0);
        checkOutput("t1_underrun", underrun_cnt, 1);
        checkOutput("t1_fill", fill, 0);

        // Stall: a lead pair occupies the pair register, then DEPTH+3 more
        applyStimulus(1'b1, 16'h1000, 16'h2000, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("t2_lead_valid", out_valid, 1);
        checkOutput("t2_lead_word", {dout_sel, dout}, {1'b0, dac(16'h1000)});
        for (int k = 1; k <= DEPTH + 3; k++) begin
            applyStimulus(1'b1, 16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
            checkOutput("t2_in_ready", in_ready, (k <= DEPTH) ? 1 : 0);
            checkOutput("t2_hold", {out_valid, dout_sel, dout}, {2'b10, dac(16'h1000)});
            tick();
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput("t2_fill", fill, DEPTH);
        checkOutput("t2_in_ready_full", in_ready, 0);
        checkOutput("t2_drop", drop_cnt, 3);
        checkOutput("t2_hold_end", {out_valid, dout_sel, dout}, {2'b10, dac(16'h1000)});

        // Drain with out_ready toggling while a ready-respecting source refills
        exp_q.push_back({1'b0, dac(16'h1000)});
        exp_q.push_back({1'b1, dac(16'h2000)});
        for (int k = 1; k <= DEPTH; k++) begin
            exp_q.push_back({1'b0, dac(16'h1000 + 16'(k))});
            exp_q.push_back({1'b1, dac(16'h2000 + 16'(k))});
        end
        pushed = 0;
        cyc = 0;
        while ((pushed < 40 || exp_q.size() != 0) && cyc < 800) begin
            ni = 16'h3000 + 16'(pushed);
            nq = 16'hC000 + 16'(pushed);
            sent = (pushed < 40) && in_ready;
            applyStimulus(sent, ni, nq, (cyc % 2) == 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("t3_extra_word", {dout_sel, dout}, 17'h1FFFF);
                end else begin
                    checkOutput("t3_word", {dout_sel, dout}, exp_q.pop_front());
                end
            end
            if (sent) begin
                exp_q.push_back({1'b0, dac(ni)});
                exp_q.push_back({1'b1, dac(nq)});
                pushed++;
            end
            tick();
            cyc++;
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput("t3_drained", exp_q.size(), 0);
        checkOutput("t3_idle_valid", out_valid, 0);
        checkOutput("t3_fill", fill, 0);
        checkOutput("t3_no_new_drops", drop_cnt, 3);
        checkOutput("t3_underrun", underrun_cnt, 2);

        // Async reset while in SEND_Q with 5 pairs queued
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 16'h5000 + 16'(k), 16'h6000 + 16'(k), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput("t4_pre_word", {out_valid, dout_sel, dout}, {2'b10, dac(16'h5000)});
        checkOutput("t4_pre_fill", fill, 5);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput("t4_in_q", {out_valid, dout_sel, dout}, {2'b11, dac(16'h6000)});
        checkOutput("t4_in_q_fill", fill, 5);
        #2 reset = 1'b1;
        #1;
        checkOutput("t4_rst_valid", out_valid, 0);
        checkOutput("t4_rst_dout", dout, 0);
        checkOutput("t4_rst_sel", dout_sel, 0);
        checkOutput("t4_rst_fill", fill, 0);
        checkOutput("t4_rst_in_ready", in_ready, 1);
        checkOutput("t4_rst_counts", {drop_cnt, underrun_cnt}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("t4_quiet", {out_valid, fill}, 0);
        end
        applyStimulus(1'b1, 16'h0ABC, 16'hF123, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        checkOutput("t4_new_lat", out_valid, 0);
        tick();
        checkOutput("t4_new_i", {out_valid, dout_sel, dout}, {2'b10, dac(16'h0ABC)});
        tick();
        checkOutput("t4_new_q", {out_valid, dout_sel, dout}, {2'b11, dac(16'hF123)});
        tick();

        // Extreme values through the output stage
        applyStimulus(1'b1, 16'h8000, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        tick();
        checkOutput("t5_i", {out_valid, dout_sel, dout}, {2'b10, EXP5_I});
        tick();
        checkOutput("t5_q", {out_valid, dout_sel, dout}, {2'b11, EXP5_Q});
        tick();
        checkOutput("t5_idle", out_valid, 0);

        // Drop counter saturation on the CNT_W=4, DEPTH=4 instance
        s_in_valid = 1'b1;
        s_out_ready = 1'b0;
        repeat (5) tick();
        checkOutput("t6_fill_full", s_fill, 4);
        checkOutput("t6_drop_zero", s_drop_cnt, 0);
        repeat (5) tick();
        checkOutput("t6_drop_5", s_drop_cnt, 5);
        repeat (10) tick();
        checkOutput("t6_drop_max", s_drop_cnt, 4'hF);
        repeat (20) tick();
        s_in_valid = 1'b0;
        checkOutput("t6_drop_sat", s_drop_cnt, 4'hF);
        checkOutput("t6_in_ready", s_in_ready, 0);
        checkOutput("t6_word", {s_out_valid, s_dout_sel, s_dout}, {2'b10, dac(16'h1234)});

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
